// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch (IF)
// and load/store (LS) requesters of a core. One transaction is in flight at a
// time: IDLE -> ACCESS -> (WAIT) -> RESP -> IDLE.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-low reset
//   if_req/if_addr      fetch request; if_gnt accept pulse
//   if_rvalid/if_rdata  fetch response pulse and data
//   ls_req/ls_we/...    load/store request; ls_gnt accept pulse
//   ls_rvalid/ls_rdata  load data / store completion pulse (rdata 0 on store)
//   mem_*               single-port memory interface, read data valid
//                       MEM_LATENCY cycles after mem_en
//   busy                high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2,
    parameter int LS_PRIORITY = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Counter reload value: WAIT cycles still to go after ACCESS.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    logic [1:0]        state_r;
    logic [3:0]        cnt_r;
    logic              owner_ls_r;
    logic              last_ls_r;
    logic              store_r;
    logic              if_gnt_r;
    logic              ls_gnt_r;
    logic              if_rvalid_r;
    logic              ls_rvalid_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [STRB_W-1:0] mem_wstrb_r;

    logic              grant_ls_s;
    logic              grant_store_s;

    // Winner selection; on a tie with round-robin the side not granted last
    // wins, so with last_ls_r reset to 0 the first tie goes to LS.
    always_comb begin
        grant_ls_s = 1'b0;
        if (ls_req && !if_req) begin
            grant_ls_s = 1'b1;
        end else if (ls_req && if_req) begin
            grant_ls_s = (LS_PRIORITY != 0) ? 1'b1 : !last_ls_r;
        end else begin
            grant_ls_s = 1'b0;
        end
        grant_store_s = grant_ls_s & ls_we;
    end

    // Transaction sequencer: captures the winning request and produces the
    // registered gnt / mem_* / rvalid pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            owner_ls_r  <= 1'b0;
            last_ls_r   <= 1'b0;
            store_r     <= 1'b0;
            if_gnt_r    <= 1'b0;
            ls_gnt_r    <= 1'b0;
            if_rvalid_r <= 1'b0;
            ls_rvalid_r <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wstrb_r <= '0;
        end else begin
            // Pulse outputs default low; the mem_* bus is only driven in ACCESS.
            if_gnt_r    <= 1'b0;
            ls_gnt_r    <= 1'b0;
            if_rvalid_r <= 1'b0;
            ls_rvalid_r <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wstrb_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (if_req || ls_req) begin
                        owner_ls_r  <= grant_ls_s;
                        last_ls_r   <= grant_ls_s;
                        store_r     <= grant_store_s;
                        if_gnt_r    <= !grant_ls_s;
                        ls_gnt_r    <= grant_ls_s;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= grant_store_s;
                        mem_addr_r  <= grant_ls_s ? ls_addr : if_addr;
                        mem_wdata_r <= grant_ls_s ? ls_wdata : '0;
                        // Strobes are meaningless on reads, keep them at zero.
                        mem_wstrb_r <= grant_store_s ? ls_wstrb : '0;
                        state_r     <= ST_ACCESS;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    cnt_r <= LAT_M1;
                    if (MEM_LATENCY > 1) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r     <= ST_RESP;
                        if_rvalid_r <= !owner_ls_r;
                        ls_rvalid_r <= owner_ls_r;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd1) begin
                        state_r     <= ST_RESP;
                        if_rvalid_r <= !owner_ls_r;
                        ls_rvalid_r <= owner_ls_r;
                    end else begin
                        state_r <= ST_WAIT;
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_r;
    assign ls_gnt    = ls_gnt_r;
    assign if_rvalid = if_rvalid_r;
    assign ls_rvalid = ls_rvalid_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign busy      = (state_r != ST_IDLE);

    // Read data arrives in the RESP cycle itself, so it is passed straight
    // through, gated to zero outside the owner's rvalid and on stores.
    assign if_rdata = if_rvalid_r ? mem_rdata : '0;
    assign ls_rdata = (ls_rvalid_r && !store_r) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench. Three arbiters share one stimulus:
//   u0: MEM_LATENCY=2, round-robin
//   u1: MEM_LATENCY=2, LS priority
//   u2: MEM_LATENCY=1, round-robin
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic [31:0] mem_rdata;

    logic [2:0]  if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata [3];
    logic [31:0] ls_rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata[3];
    logic [3:0]  mem_wstrb[3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2), .LS_PRIORITY(0)) u0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]),
        .ls_rdata(ls_rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
        .mem_rdata(mem_rdata), .busy(busy[0])
    );

    mem_port_arbiter #(.MEM_LATENCY(2), .LS_PRIORITY(1)) u1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]),
        .ls_rdata(ls_rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
        .mem_rdata(mem_rdata), .busy(busy[1])
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .LS_PRIORITY(0)) u2 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[2]),
        .if_rvalid(if_rvalid[2]), .if_rdata(if_rdata[2]),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt[2]), .ls_rvalid(ls_rvalid[2]),
        .ls_rdata(ls_rdata[2]), .mem_en(mem_en[2]), .mem_we(mem_we[2]),
        .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]), .mem_wstrb(mem_wstrb[2]),
        .mem_rdata(mem_rdata), .busy(busy[2])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then looked at 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    int  g0_n, g2_n, g1_ls, g1_if;
    logic g0_seq [16];
    logic g2_seq [16];
    int  e0_t [16];
    int  e2_t [16];
    bit  seen;
    logic seen_if;

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_addr   = 32'h0;
        ls_wdata  = 32'h0;
        ls_wstrb  = 4'h0;
        mem_rdata = 32'h0050_0093;
        step();
        step();
        check_eq("rst_busy",     {61'd0, busy},    64'd0);
        check_eq("rst_mem_en",   {61'd0, mem_en},  64'd0);
        check_eq("rst_gnt",      {58'd0, if_gnt, ls_gnt}, 64'd0);
        check_eq("rst_if_rdata", if_rdata[0], 64'd0);
        check_eq("rst_ls_rdata", ls_rdata[0], 64'd0);
        check_eq("rst_mem_addr", mem_addr[0], 64'd0);
        reset = 1'b1;

        // ---- 1: single IF read ------------------------------------------
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        step();
        check_eq("t1_if_gnt",    if_gnt[0], 64'd1);
        check_eq("t1_mem_en",    mem_en[0], 64'd1);
        check_eq("t1_mem_addr",  mem_addr[0], 64'h10);
        check_eq("t1_mem_wstrb", mem_wstrb[0], 64'd0);
        check_eq("t1_ls_gnt",    ls_gnt[0], 64'd0);
        check_eq("t1_busy",      busy[0], 64'd1);
        check_eq("t6_mem_en",    mem_en[2], 64'd1);
        if_req = 1'b0;
        step();
        check_eq("t1_wait_mem_en", mem_en[0], 64'd0);
        check_eq("t1_wait_rvalid", if_rvalid[0], 64'd0);
        check_eq("t1_wait_rdata",  if_rdata[0], 64'd0);
        check_eq("t6_rvalid",      if_rvalid[2], 64'd1);
        check_eq("t6_rdata",       if_rdata[2], 64'h0050_0093);
        step();
        check_eq("t1_rvalid", if_rvalid[0], 64'd1);
        check_eq("t1_rdata",  if_rdata[0], 64'h0050_0093);
        check_eq("t1_ls_rvalid", ls_rvalid[0], 64'd0);
        step();
        check_eq("t1_busy_low",  busy[0], 64'd0);
        check_eq("t1_rvalid_lo", if_rvalid[0], 64'd0);

        // ---- 2: LS store --------------------------------------------------
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h0000_0100;
        ls_wdata = 32'hDEAD_BEEF;
        ls_wstrb = 4'b0011;
        step();
        check_eq("t2_ls_gnt",    ls_gnt[0], 64'd1);
        check_eq("t2_if_gnt",    if_gnt[0], 64'd0);
        check_eq("t2_mem_en",    mem_en[0], 64'd1);
        check_eq("t2_mem_we",    mem_we[0], 64'd1);
        check_eq("t2_mem_wstrb", mem_wstrb[0], 64'h3);
        check_eq("t2_mem_wdata", mem_wdata[0], 64'hDEAD_BEEF);
        check_eq("t2_mem_addr",  mem_addr[0], 64'h100);
        ls_req = 1'b0;
        step();
        check_eq("t2_wait_rvalid", ls_rvalid[0], 64'd0);
        check_eq("t2_wait_we",     mem_we[0], 64'd0);
        step();
        check_eq("t2_ls_rvalid", ls_rvalid[0], 64'd1);
        check_eq("t2_ls_rdata",  ls_rdata[0], 64'd0);
        check_eq("t2_if_rvalid", if_rvalid[0], 64'd0);
        step();
        ls_we    = 1'b0;
        ls_wstrb = 4'b0000;

        // ---- 3/4/6: tie held from reset ------------------------------------
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        ls_req  = 1'b1;
        ls_addr = 32'h0000_0200;
        do_reset();
        g0_n = 0; g2_n = 0; g1_ls = 0; g1_if = 0;
        for (int i = 0; i < 16; i++) begin
            g0_seq[i] = 1'b0; g2_seq[i] = 1'b0; e0_t[i] = 0; e2_t[i] = 0;
        end
        for (int c = 0; c < 16; c++) begin
            step();
            if (mem_en[0]) begin
                e0_t[g0_n]   = c;
                g0_seq[g0_n] = ls_gnt[0];
                g0_n++;
            end
            if (mem_en[2]) begin
                e2_t[g2_n]   = c;
                g2_seq[g2_n] = ls_gnt[2];
                g2_n++;
            end
            if (ls_gnt[1]) g1_ls++;
            if (if_gnt[1]) g1_if++;
        end
        check_eq("t3_grants", g0_n, 64'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t3_order%0d", k), g0_seq[k], (k % 2 == 0) ? 64'd1 : 64'd0);
        end
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("t3_space%0d", k), e0_t[k+1] - e0_t[k], 64'd4);
        end
        check_eq("t4_ls_grants", g1_ls, 64'd4);
        check_eq("t4_if_grants", g1_if, 64'd0);
        check_eq("t6_grants", g2_n, 64'd6);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("t6_order%0d", k), g2_seq[k], (k % 2 == 0) ? 64'd1 : 64'd0);
        end
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("t6_space%0d", k), e2_t[k+1] - e2_t[k], 64'd3);
        end

        // LS drops: the LS-priority arbiter must now serve IF.
        ls_req  = 1'b0;
        seen    = 1'b0;
        seen_if = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!seen && (if_gnt[1] || ls_gnt[1])) begin
                seen    = 1'b1;
                seen_if = if_gnt[1];
            end
        end
        check_eq("t4_if_served", {62'd0, seen, seen_if}, 64'h3);

        // ---- 5: reset in WAIT ----------------------------------------------
        if_req = 1'b0;
        do_reset();
        step();
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        step();
        check_eq("t5_gnt", if_gnt[0], 64'd1);
        if_req = 1'b0;
        step();
        check_eq("t5_in_wait", {62'd0, busy[0], mem_en[0]}, 64'h2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("t5_busy",    busy[0], 64'd0);
        check_eq("t5_outs",    {58'd0, if_gnt[0], ls_gnt[0], mem_en[0], mem_we[0],
                                if_rvalid[0], ls_rvalid[0]}, 64'd0);
        check_eq("t5_addr",    mem_addr[0], 64'd0);
        check_eq("t5_rdata",   if_rdata[0], 64'd0);
        step();
        check_eq("t5_no_rvalid_a", if_rvalid[0], 64'd0);
        step();
        check_eq("t5_no_rvalid_b", if_rvalid[0], 64'd0);
        if_req  = 1'b1;
        if_addr = 32'h0000_0084;
        step();
        check_eq("t5_new_gnt",  if_gnt[0], 64'd1);
        check_eq("t5_new_addr", mem_addr[0], 64'h84);
        if_req = 1'b0;
        step();
        step();
        check_eq("t5_new_rvalid", if_rvalid[0], 64'd1);
        check_eq("t5_new_rdata",  if_rdata[0], 64'h0050_0093);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
